serial_operand_loader: RTL and testbench

- Parametrised successor to the byte-serial operand entry and display path.
- Assembles NUM_OPS operands of DATA_W bits from IN_W-bit switch input, one byte per debounced `enter` press.
- Hands the operands to an external combinational arithmetic unit, registers its result, and shows it paged across NUM_DISP seven-segment displays.
- Sits between board switches/buttons and the arithmetic unit, one level below the top-level datapath.

---
 rtl/serial_operand_loader.sv | 187 ++++++++++++++++++
 tb/tb_serial_operand_loader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_loader.sv
// serial_operand_loader: byte-serial operand entry, compute launch and paged hex display of the result.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enter               raw button: capture byte (LOAD) / next page (SHOW)
//   inputdata[IN_W]     switch data, shifted MSB-first into the operand being assembled
//   loaddata            raw button: abort (LOAD) / launch compute (WAIT_GO) / new transaction (SHOW)
//   result_in[DATA_W]   combinational result from the arithmetic unit
//   operands            operand k at [k*DATA_W +: DATA_W]
//   start               one-cycle pulse when compute is launched
//   inputdata_ready     all operands loaded, awaiting loaddata
//   page                current result page shown
//   disp                digit d at [d*7 +: 7], active-low gfedcba
// Optional macro DEBOUNCE_EN adds a counter debouncer (DEBOUNCE_CYC stable cycles) per button.
module serial_operand_loader #(
    parameter int DATA_W       = 32,
    parameter int IN_W         = 8,
    parameter int NUM_OPS      = 2,
    parameter int NUM_DISP     = 4,
    parameter int DEBOUNCE_CYC = 16,
    localparam int PAGES       = DATA_W / (4 * NUM_DISP),
    localparam int PW          = PAGES > 1 ? $clog2(PAGES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enter,
    input  logic [IN_W-1:0]           inputdata,
    input  logic                      loaddata,
    input  logic [DATA_W-1:0]         result_in,
    output logic [NUM_OPS*DATA_W-1:0] operands,
    output logic                      start,
    output logic                      inputdata_ready,
    output logic [PW-1:0]             page,
    output logic [NUM_DISP*7-1:0]     disp
);
    localparam int BPW = DATA_W / IN_W;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
    localparam int IW  = NUM_OPS > 1 ? $clog2(NUM_OPS) : 1;
    localparam int NW  = 4 * NUM_DISP;
    localparam logic [16*7-1:0] SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};

    if (DATA_W % IN_W != 0 || DATA_W % NW != 0 || NUM_OPS < 1 || DEBOUNCE_CYC < 1) begin : g_bad
        $error("serial_operand_loader: illegal parameter combination");
    end

    typedef enum logic [1:0] {LOAD, WAIT_GO, CAPTURE, SHOW} state_t;

    state_t                    state, state_nxt;
    logic [NUM_OPS*DATA_W-1:0] ops, ops_nxt;
    logic [BW-1:0]             byte_cnt, byte_nxt;
    logic [IW-1:0]             op_idx, idx_nxt;
    logic [PW-1:0]             page_nxt;
    logic [DATA_W-1:0]         res, res_nxt, shifted;
    logic                      start_nxt, rdy_nxt;
    logic [1:0]                s1, s2, lvl, lvl_q, ev;
    logic                      en_ev, ld_ev;
    logic [IW-1:0]             sel;
    logic [NW-1:0]             disp_val;

    // bit 0 = enter, bit 1 = loaddata
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            lvl_q <= '0;
        end else begin
            s1    <= {loaddata, enter};
            s2    <= s1;
            lvl_q <= lvl;
        end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    for (genvar i = 0; i < 2; i++) begin : g_db
        logic          filt;
        logic [CW-1:0] cnt;
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                filt <= 1'b0;
                cnt  <= '0;
            end else if (s2[i] == filt) begin
                cnt  <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                filt <= s2[i];
                cnt  <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        assign lvl[i] = filt;
    end
`else
    assign lvl = s2;
`endif

    assign ev    = lvl & ~lvl_q;
    assign ld_ev = ev[1];
    assign en_ev = ev[0] & ~ev[1];

    if (DATA_W > IN_W) begin : g_sh
        assign shifted = {ops[op_idx*DATA_W +: DATA_W-IN_W], inputdata};
    end else begin : g_nsh
        assign shifted = inputdata;
    end

    always_comb begin
        state_nxt = state;
        ops_nxt   = ops;
        byte_nxt  = byte_cnt;
        idx_nxt   = op_idx;
        page_nxt  = page;
        res_nxt   = res;
        start_nxt = 1'b0;
        rdy_nxt   = inputdata_ready;
        case (state)
            LOAD:
                if (ld_ev) begin
                    ops_nxt  = '0;
                    byte_nxt = '0;
                    idx_nxt  = '0;
                end else if (en_ev) begin
                    ops_nxt[op_idx*DATA_W +: DATA_W] = shifted;
                    byte_nxt = byte_cnt == BW'(BPW - 1) ? '0 : byte_cnt + 1'b1;
                    if (byte_cnt == BW'(BPW - 1)) begin
                        if (op_idx == IW'(NUM_OPS - 1)) begin
                            state_nxt = WAIT_GO;
                            rdy_nxt   = 1'b1;
                        end else begin
                            idx_nxt = op_idx + 1'b1;
                        end
                    end
                end
            WAIT_GO:
                if (ld_ev) begin
                    start_nxt = 1'b1;
                    rdy_nxt   = 1'b0;
                    state_nxt = CAPTURE;
                end
            CAPTURE: begin
                res_nxt   = result_in;
                page_nxt  = '0;
                state_nxt = SHOW;
            end
            SHOW:
                if (ld_ev) begin
                    ops_nxt   = '0;
                    byte_nxt  = '0;
                    idx_nxt   = '0;
                    page_nxt  = '0;
                    state_nxt = LOAD;
                end else if (en_ev) begin
                    page_nxt = page == PW'(PAGES - 1) ? '0 : page + 1'b1;
                end
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state           <= LOAD;
            ops             <= '0;
            byte_cnt        <= '0;
            op_idx          <= '0;
            page            <= '0;
            res             <= '0;
            start           <= 1'b0;
            inputdata_ready <= 1'b0;
        end else begin
            state           <= state_nxt;
            ops             <= ops_nxt;
            byte_cnt        <= byte_nxt;
            op_idx          <= idx_nxt;
            page            <= page_nxt;
            res             <= res_nxt;
            start           <= start_nxt;
            inputdata_ready <= rdy_nxt;
        end

    assign operands = ops;
    assign sel      = state == LOAD ? op_idx : IW'(NUM_OPS - 1);
    assign disp_val = state == SHOW ? res[page*NW +: NW] : ops[sel*DATA_W +: NW];

    for (genvar d = 0; d < NUM_DISP; d++) begin : g_dig
        assign disp[d*7 +: 7] = SEG[disp_val[d*4 +: 4]*7 +: 7];
    end
endmodule

// File: tb/tb_serial_operand_loader.sv
// tb_serial_operand_loader: scoreboard bench for serial_operand_loader with default parameters.
module tb_serial_operand_loader;
    localparam int DB = 8;
`ifdef DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0, reset = 1'b1, enter = 1'b0, loaddata = 1'b0;
    logic [7:0]  inputdata = '0;
    logic [31:0] result_in = '0;
    logic [63:0] operands;
    logic        start, inputdata_ready;
    logic [0:0]  page;
    logic [27:0] disp;

    int          checks = 0, errors = 0, start_cnt = 0;
    logic [63:0] sb[$];
    logic [63:0] pre_ops;
    logic        pre_rdy;
    logic [6:0]  seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [7:0]  fp [8] = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
    logic [7:0]  tail [5] = '{8'h99, 8'h88, 8'h77, 8'h66, 8'h55};

    serial_operand_loader #(.DEBOUNCE_CYC(DB)) dut (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
        .loaddata(loaddata), .result_in(result_in), .operands(operands),
        .start(start), .inputdata_ready(inputdata_ready), .page(page), .disp(disp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] glyphs(input logic [15:0] v);
        return {seg[v[15:12]], seg[v[11:8]], seg[v[7:4]], seg[v[3:0]]};
    endfunction

    // raise the chosen buttons for `hold` cycles; snapshot state one edge before the action edge
    task automatic btn(input logic [7:0] b, input logic e, input logic l, input int hold);
        @(negedge clk);
        inputdata = b;
        enter     = e;
        loaddata  = l;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (i == LAT) begin
                pre_ops = operands;
                pre_rdy = inputdata_ready;
            end
        end
        enter    = 1'b0;
        loaddata = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // scoreboard: each compute launch pops the operands expected at that moment
    always @(negedge clk)
        if (start) begin
            start_cnt++;
            if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
            else chk("start_ops", operands, sb.pop_front());
        end

    initial begin
        #1;
        chk("rst_ops", operands, 64'h0);
        chk("rst_rdy", 64'(inputdata_ready), 64'h0);
        chk("rst_start", 64'(start), 64'h0);
        chk("rst_page", 64'(page), 64'h0);
        chk("rst_disp", 64'(disp), 64'(glyphs(16'h0)));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        btn(8'h11, 1, 0, LAT);
        btn(8'h22, 1, 0, LAT);
        btn(8'h33, 1, 0, LAT);
        chk("load3_ops", operands, 64'h112233);
        chk("load3_disp", 64'(disp), 64'(glyphs(16'h2233)));
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_ops", operands, 64'h0);
        chk("arst_rdy", 64'(inputdata_ready), 64'h0);
        chk("arst_disp", 64'(disp), 64'(glyphs(16'h0)));
        @(negedge clk);
        reset = 1'b0;
        btn(8'h5A, 1, 0, LAT);
        chk("post_rst_byte", operands, 64'h5A);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            btn(fp[i], 1, 0, LAT);
            if (i == 6) chk("rdy_after7", 64'(inputdata_ready), 64'h0);
            if (i == 7) begin
                chk("rdy_before8", 64'(pre_rdy), 64'h0);
                chk("rdy_after8", 64'(inputdata_ready), 64'h1);
            end
        end
        chk("fp_ops", operands, {32'h40000000, 32'h3F800000});
        chk("wait_disp", 64'(disp), 64'(glyphs(16'h0)));
        btn(8'hFF, 1, 0, LAT);
        chk("wait_enter_ign", operands, {32'h40000000, 32'h3F800000});
        chk("wait_rdy_held", 64'(inputdata_ready), 64'h1);

        result_in = 32'h40000000;
        sb.push_back({32'h40000000, 32'h3F800000});
        start_cnt = 0;
        btn(8'h00, 0, 1, LAT);
        chk("start_once", 64'(start_cnt), 64'd1);
        chk("show_rdy", 64'(inputdata_ready), 64'h0);
        chk("show_page0", 64'(page), 64'h0);
        chk("show_disp0", 64'(disp), 64'(glyphs(16'h0000)));
        result_in = 32'hDEADBEEF;
        btn(8'h00, 1, 0, LAT);
        chk("show_page1", 64'(page), 64'h1);
        chk("show_disp1", 64'(disp), 64'(glyphs(16'h4000)));
        btn(8'h00, 1, 0, LAT);
        chk("show_wrap", 64'(page), 64'h0);
        chk("show_hold_ops", operands, {32'h40000000, 32'h3F800000});

        btn(8'h00, 0, 1, LAT);
        chk("new_txn_ops", operands, 64'h0);
        for (int i = 0; i < 8; i++) btn(8'(i + 1), 1, 0, LAT);
        chk("seq_ops", operands, {32'h05060708, 32'h01020304});
        result_in = 32'hC0DE1234;
        sb.push_back({32'h05060708, 32'h01020304});
        start_cnt = 0;
        btn(8'h00, 0, 1, LAT);
        chk("start_once2", 64'(start_cnt), 64'd1);
        chk("show2_disp0", 64'(disp), 64'(glyphs(16'h1234)));
        btn(8'h00, 1, 0, LAT);
        chk("show2_disp1", 64'(disp), 64'(glyphs(16'hC0DE)));

        btn(8'h00, 0, 1, LAT);
        btn(8'hA5, 1, 0, 10);
        chk("held_pre", pre_ops, 64'h0);
        chk("held_one", operands, 64'hA5);

        btn(8'h11, 1, 0, LAT);
        btn(8'h22, 1, 0, LAT);
        btn(8'h77, 1, 1, LAT);
        chk("both_abort", operands, 64'h0);
        chk("both_rdy", 64'(inputdata_ready), 64'h0);
        for (int i = 0; i < 5; i++) btn(tail[i], 1, 0, LAT);
        chk("after_abort", operands, {32'h00000055, 32'h99887766});

`ifdef DEBOUNCE_EN
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            inputdata = 8'hE1;
            enter = 1'b1;
            repeat (3) @(negedge clk);
            enter = 1'b0;
            repeat (1) @(negedge clk);
        end
        repeat (LAT + 2) @(negedge clk);
        chk("db_bounce", operands, {32'h00000055, 32'h99887766});
        btn(8'hE2, 1, 0, 12);
        chk("db_pre", pre_ops, {32'h00000055, 32'h99887766});
        chk("db_post", operands, {32'h000055E2, 32'h99887766});
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
